wb_bram_arb: RTL and testbench

//  Two-master Wishbone arbiter and controller for the single-port 512x32 boot/program BRAM.

---
 rtl/wb_bram_pkg.sv | 15 +
 rtl/rr_arb2.sv | 55 +++++
 rtl/wb_bram_arb.sv | 137 +++++++++++++
 tb/tb_wb_bram_arb.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_bram_pkg.sv
// rtl/wb_bram_pkg.sv - shared types and defaults for the two-master Wishbone BRAM arbiter
package wb_bram_pkg;

    localparam int          MEM_AW_DEF   = 9;
    localparam logic [20:0] BASE_HI_DEF  = 21'h0;
    localparam int          LOCK_MAX_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP,
        ST_ERR
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter with bounded bus lock for the current owner
module rr_arb2
    import wb_bram_pkg::*;
#(
    parameter int LOCK_MAX = LOCK_MAX_DEF,
    parameter int CW       = $clog2(LOCK_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    req,
    input  logic          owner_cyc,
    input  logic          arb_en,
    output logic          win,
    output logic          gnt,
    output logic          prio,
    output logic [CW-1:0] lock_cnt
);

    logic lock_hold;

    // lock_cnt==0 means the owner let go of cyc since its last transfer, so no lock applies
    assign lock_hold = owner_cyc && req[gnt] && (lock_cnt != '0) && (lock_cnt < CW'(LOCK_MAX));

    always_comb begin
        win = gnt;
        if (lock_hold) begin
            win = gnt;
        end else if (req == 2'b11) begin
            win = prio;
        end else begin
            win = req[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt      <= 1'b0;
            prio     <= 1'b0;
            lock_cnt <= '0;
        end else if (arb_en) begin
            gnt  <= win;
            prio <= ~win;
            if (win == gnt && owner_cyc) begin
                if (lock_cnt < CW'(LOCK_MAX)) begin
                    lock_cnt <= lock_cnt + CW'(1);
                end
            end else begin
                lock_cnt <= CW'(1);
            end
        end else if (!owner_cyc) begin
            lock_cnt <= '0;
        end
    end

endmodule

// File: rtl/wb_bram_arb.sv
// rtl/wb_bram_arb.sv - two-master Wishbone arbiter and sequencer for a single-port 512x32 BRAM
module wb_bram_arb
    import wb_bram_pkg::*;
#(
    parameter int                 MEM_AW   = MEM_AW_DEF,
    parameter logic [29-MEM_AW:0] BASE_HI  = BASE_HI_DEF,
    parameter int                 LOCK_MAX = LOCK_MAX_DEF
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              m0_cyc,
    input  logic              m0_stb,
    input  logic [31:0]       m0_adr,
    input  logic              m0_we,
    input  logic [31:0]       m0_dat_i,
    input  logic [3:0]        m0_sel,
    output logic [31:0]       m0_dat_o,
    output logic              m0_ack,
    output logic              m0_err,
    input  logic              m1_cyc,
    input  logic              m1_stb,
    input  logic [31:0]       m1_adr,
    input  logic              m1_we,
    input  logic [31:0]       m1_dat_i,
    input  logic [3:0]        m1_sel,
    output logic [31:0]       m1_dat_o,
    output logic              m1_ack,
    output logic              m1_err,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_di,
    input  logic [31:0]       mem_do,
    output logic              grant
);

    localparam int CW = $clog2(LOCK_MAX + 1);

    state_t              state, state_nx;
    logic [MEM_AW-1:0]   waddr_q;
    logic [31:0]         dat_q;
    logic                we_q;
    logic [3:0]          sel_q;
    logic [1:0]          req;
    logic                arb_en, win, gnt, prio, owner_cyc;
    logic [CW-1:0]       lock_cnt;
    logic [MEM_AW-1:0]   win_waddr;
    logic [29-MEM_AW:0]  win_hi;
    logic                resp_ack, resp_err;
    logic [31:0]         rdata;
    logic                unused_bits;

    assign req       = {m1_cyc & m1_stb, m0_cyc & m0_stb};
    assign arb_en    = (state == ST_IDLE) && (req != 2'b00);
    assign owner_cyc = gnt ? m1_cyc : m0_cyc;
    assign win_waddr = win ? m1_adr[MEM_AW+1:2] : m0_adr[MEM_AW+1:2];
    assign win_hi    = win ? m1_adr[31:MEM_AW+2] : m0_adr[31:MEM_AW+2];

    rr_arb2 #(
        .LOCK_MAX (LOCK_MAX),
        .CW       (CW)
    ) u_arb (
        .clk       (sys_clk),
        .rst_n     (rst_n),
        .req       (req),
        .owner_cyc (owner_cyc),
        .arb_en    (arb_en),
        .win       (win),
        .gnt       (gnt),
        .prio      (prio),
        .lock_cnt  (lock_cnt)
    );

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            waddr_q <= '0;
            dat_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
        end else begin
            state <= state_nx;
            if (arb_en) begin
                waddr_q <= win_waddr;
                dat_q   <= win ? m1_dat_i : m0_dat_i;
                we_q    <= win ? m1_we : m0_we;
                sel_q   <= win ? m1_sel : m0_sel;
            end
        end
    end

    // The BRAM write commits at the end of ACCESS regardless of cyc; only the response is qualified
    always_comb begin
        state_nx = state;
        mem_en   = 1'b0;
        mem_we   = '0;
        mem_addr = '0;
        mem_di   = '0;
        resp_ack = 1'b0;
        resp_err = 1'b0;
        case (state)
            ST_IDLE: begin
                if (arb_en) begin
                    state_nx = (win_hi != BASE_HI) ? ST_ERR : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                state_nx = ST_RESP;
                mem_en   = 1'b1;
                mem_addr = waddr_q;
                mem_we   = sel_q & {4{we_q}};
                mem_di   = dat_q;
            end
            ST_RESP: begin
                state_nx = ST_IDLE;
                resp_ack = owner_cyc;
            end
            ST_ERR: begin
                state_nx = ST_IDLE;
                resp_err = owner_cyc;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign rdata    = (state == ST_RESP && !we_q) ? mem_do : 32'h0;
    assign m0_ack   = resp_ack & ~gnt;
    assign m1_ack   = resp_ack & gnt;
    assign m0_err   = resp_err & ~gnt;
    assign m1_err   = resp_err & gnt;
    assign m0_dat_o = gnt ? 32'h0 : rdata;
    assign m1_dat_o = gnt ? rdata : 32'h0;
    assign grant    = gnt;

    assign unused_bits = ^{prio, lock_cnt, m0_adr[1:0], m1_adr[1:0]};

endmodule

// File: tb/tb_wb_bram_arb.sv
// tb/tb_wb_bram_arb.sv - scoreboard bench for wb_bram_arb with a behavioural 512x32 BRAM
module tb_wb_bram_arb;

    logic        sys_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic        m0_cyc = 1'b0, m0_stb = 1'b0, m0_we = 1'b0;
    logic [31:0] m0_adr = '0, m0_dat_i = '0;
    logic [3:0]  m0_sel = '0;
    logic        m1_cyc = 1'b0, m1_stb = 1'b0, m1_we = 1'b0;
    logic [31:0] m1_adr = '0, m1_dat_i = '0;
    logic [3:0]  m1_sel = '0;
    logic [31:0] m0_dat_o, m1_dat_o;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [8:0]  mem_addr;
    logic [31:0] mem_di;
    logic [31:0] mem_do = '0;
    logic        grant;
    logic [31:0] bram [512] = '{default: '0};

    int total = 0;
    int bad   = 0;
    int lat0, lat1;

    typedef struct packed {
        logic        m;
        logic        err;
        logic [31:0] dat;
    } resp_t;

    typedef struct packed {
        logic [8:0]  addr;
        logic [3:0]  we;
        logic [31:0] di;
    } acc_t;

    resp_t exp_resp[$];
    acc_t  exp_acc[$];

    always #5 sys_clk = ~sys_clk;

    wb_bram_arb dut (
        .sys_clk  (sys_clk),
        .rst_n    (rst_n),
        .m0_cyc   (m0_cyc),
        .m0_stb   (m0_stb),
        .m0_adr   (m0_adr),
        .m0_we    (m0_we),
        .m0_dat_i (m0_dat_i),
        .m0_sel   (m0_sel),
        .m0_dat_o (m0_dat_o),
        .m0_ack   (m0_ack),
        .m0_err   (m0_err),
        .m1_cyc   (m1_cyc),
        .m1_stb   (m1_stb),
        .m1_adr   (m1_adr),
        .m1_we    (m1_we),
        .m1_dat_i (m1_dat_i),
        .m1_sel   (m1_sel),
        .m1_dat_o (m1_dat_o),
        .m1_ack   (m1_ack),
        .m1_err   (m1_err),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_di   (mem_di),
        .mem_do   (mem_do),
        .grant    (grant)
    );

    always @(posedge sys_clk) begin
        if (mem_en) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_we[b]) bram[mem_addr][b*8 +: 8] <= mem_di[b*8 +: 8];
            end
            mem_do <= bram[mem_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic exp_r(input logic m, input logic err, input logic [31:0] d);
        resp_t r;
        r.m = m; r.err = err; r.dat = d;
        exp_resp.push_back(r);
    endtask

    task automatic exp_a(input logic [8:0] addr, input logic [3:0] we, input logic [31:0] di);
        acc_t a;
        a.addr = addr; a.we = we; a.di = di;
        exp_acc.push_back(a);
    endtask

    // Monitor: pops expectations whenever the DUT presents a response or a BRAM access
    always @(negedge sys_clk) begin
        resp_t r;
        acc_t  a;
        logic  got_m;
        if (rst_n) begin
            if (m0_ack | m0_err | m1_ack | m1_err) begin
                check("single_resp", $countones({m0_ack, m0_err, m1_ack, m1_err}), 1);
                check("resp_expected", exp_resp.size() != 0, 1);
                if (exp_resp.size() != 0) begin
                    r = exp_resp.pop_front();
                    got_m = m1_ack | m1_err;
                    check("resp_owner", got_m, r.m);
                    check("resp_grant", grant, r.m);
                    check("resp_err", m0_err | m1_err, r.err);
                    check("resp_data", got_m ? m1_dat_o : m0_dat_o, r.dat);
                    check("peer_data", got_m ? m0_dat_o : m1_dat_o, 0);
                end
            end
            if (mem_en) begin
                check("acc_expected", exp_acc.size() != 0, 1);
                if (exp_acc.size() != 0) begin
                    a = exp_acc.pop_front();
                    check("acc_addr", mem_addr, a.addr);
                    check("acc_we", mem_we, a.we);
                    if (a.we != 4'h0) check("acc_di", mem_di, a.di);
                end
            end
        end
    end

    task automatic drive(input logic m, input logic c, input logic s, input logic [31:0] a,
                         input logic we, input logic [31:0] d, input logic [3:0] sel);
        if (!m) begin
            m0_cyc = c; m0_stb = s; m0_adr = a; m0_we = we; m0_dat_i = d; m0_sel = sel;
        end else begin
            m1_cyc = c; m1_stb = s; m1_adr = a; m1_we = we; m1_dat_i = d; m1_sel = sel;
        end
    endtask

    task automatic wb_op(input logic m, input logic [31:0] a, input logic we, input logic [31:0] d,
                         input logic [3:0] sel, input logic hold, output int cycles);
        int  n = 0;
        logic done = 1'b0;
        drive(m, 1'b1, 1'b1, a, we, d, sel);
        while (!done && n < 100) begin
            @(negedge sys_clk);
            done = m ? (m1_ack | m1_err) : (m0_ack | m0_err);
            n++;
        end
        check("op_done", done, 1);
        cycles = n;
        @(posedge sys_clk);
        #1;
        if (!hold) drive(m, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=no finish required=finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int n;
        repeat (2) @(posedge sys_clk);
        #1;
        check("rst_mem_en", mem_en, 0);
        check("rst_grant", grant, 0);
        check("rst_resp", {m0_ack, m0_err, m1_ack, m1_err}, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        rst_n = 1'b1;
        idle(1);

        // full-word write then read back
        exp_a(9'h010, 4'hF, 32'hDEADBEEF); exp_r(1'b0, 1'b0, 32'h0);
        wb_op(1'b0, 32'h40, 1'b1, 32'hDEADBEEF, 4'hF, 1'b0, lat);
        check("t1_wr_latency", lat, 3);
        exp_a(9'h010, 4'h0, 32'h0); exp_r(1'b0, 1'b0, 32'hDEADBEEF);
        wb_op(1'b0, 32'h40, 1'b0, 32'h0, 4'hF, 1'b0, lat);
        check("t1_rd_latency", lat, 3);
        idle(1);

        // single-byte write merges into the existing word
        exp_a(9'h010, 4'b0010, 32'h0000AB00); exp_r(1'b0, 1'b0, 32'h0);
        wb_op(1'b0, 32'h40, 1'b1, 32'h0000AB00, 4'b0010, 1'b0, lat);
        exp_a(9'h010, 4'h0, 32'h0); exp_r(1'b0, 1'b0, 32'hDEADABEF);
        wb_op(1'b0, 32'h40, 1'b0, 32'h0, 4'hF, 1'b0, lat);
        idle(1);

        // out-of-window address: error, no BRAM access
        exp_r(1'b1, 1'b1, 32'h0);
        wb_op(1'b1, 32'h0001_0000, 1'b0, 32'h0, 4'hF, 1'b0, lat);
        idle(1);

        // simultaneous single transfers alternate 0,1,0,1
        for (int i = 0; i < 4; i++) begin
            exp_a(9'h040 + 9'(2 * i), 4'hF, 32'h1000_0000 + 32'(i)); exp_r(1'b0, 1'b0, 32'h0);
            exp_a(9'h010, 4'h0, 32'h0); exp_r(1'b1, 1'b0, 32'hDEADABEF);
            fork
                wb_op(1'b0, 32'h100 + 32'(8 * i), 1'b1, 32'h1000_0000 + 32'(i), 4'hF, 1'b0, lat0);
                wb_op(1'b1, 32'h40, 1'b0, 32'h0, 4'hF, 1'b0, lat1);
            join
            idle(1);
        end

        // m0 holds cyc for 20 reads; m1 gets in after 16
        for (int k = 0; k < 16; k++) begin
            exp_a(9'h010, 4'h0, 32'h0); exp_r(1'b0, 1'b0, 32'hDEADABEF);
        end
        exp_a(9'h042, 4'h0, 32'h0); exp_r(1'b1, 1'b0, 32'h1000_0001);
        for (int k = 0; k < 4; k++) begin
            exp_a(9'h010, 4'h0, 32'h0); exp_r(1'b0, 1'b0, 32'hDEADABEF);
        end
        fork
            begin
                for (int k = 0; k < 20; k++) wb_op(1'b0, 32'h40, 1'b0, 32'h0, 4'hF, k < 19, lat0);
            end
            begin
                idle(1);
                wb_op(1'b1, 32'h108, 1'b0, 32'h0, 4'hF, 1'b0, lat1);
            end
        join
        idle(1);

        // reset during ACCESS of a write aborts it
        exp_a(9'h080, 4'hF, 32'h5555AAAA);
        drive(1'b0, 1'b1, 1'b1, 32'h200, 1'b1, 32'h5555AAAA, 4'hF);
        n = 0;
        while (!mem_en && n < 10) begin
            @(negedge sys_clk);
            n++;
        end
        check("t6_access_seen", mem_en, 1);
        #2;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        #1;
        check("t6_rst_mem_en", mem_en, 0);
        check("t6_rst_resp", {m0_ack, m0_err, m1_ack, m1_err}, 0);
        check("t6_rst_mem_we", mem_we, 0);
        check("t6_rst_grant", grant, 0);
        idle(1);
        rst_n = 1'b1;
        idle(1);
        exp_a(9'h080, 4'h0, 32'h0); exp_r(1'b0, 1'b0, 32'h0);
        wb_op(1'b0, 32'h200, 1'b0, 32'h0, 4'hF, 1'b0, lat);
        check("t6_latency", lat, 3);
        exp_a(9'h010, 4'h0, 32'h0); exp_r(1'b0, 1'b0, 32'hDEADABEF);
        wb_op(1'b0, 32'h40, 1'b0, 32'h0, 4'hF, 1'b0, lat);

        idle(3);
        check("resp_queue_drained", exp_resp.size(), 0);
        check("acc_queue_drained", exp_acc.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
